mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares one unified external memory port between the instruction-fetch and data load/store requesters of the core. Uses a 4-state controller with registered bus outputs and an active-low memory acknowledge, matching the core's ACKI_n/ACKD_n convention. Returns one-cycle acknowledge pulses with captured read data. Includes starvation protection and a bus timeout. Sits between the core pipeline and the memory-side pins.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, consecutive lost arbitrations after which fetch is forced to win (1..15)
TIMEOUT_CYCLES, 64, bus cycles without ack before abort (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req  in  1  fetch request, held until i_ack
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetched word, valid with i_ack
i_ack  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, held until d_ack
d_we  in  1  1 = store
d_size  in  2  00 word, 01 half, 10 byte
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data, right-aligned
d_rdata  out  DATA_W  load data, valid with d_ack
d_ack  out  1  one-cycle data completion pulse
m_req  out  1  memory request (MREQ)
m_we  out  1  memory write (WRITE)
m_size  out  2  memory size (SIZE)
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data
m_ack_n  in  1  active-low memory acknowledge
err  out  1  one-cycle timeout pulse, coincident with the aborted ack

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - State IDLE.
  - m_req, m_we, i_ack, d_ack and err are 0.
  - m_size is 00; m_addr, m_wdata, i_rdata and d_rdata are 0.
  - Starvation and timeout counters are 0.
- Reset mid-transaction: takes effect at the next edge. m_req drops to 0 and no ack is issued.
- States: IDLE, IBUS, DBUS, RESP.
- IDLE, neither request: stay in IDLE.
- IDLE, one request: go to IBUS (fetch) or DBUS (data). Latch the address, size, we and wdata into the m_* registers and set m_req=1 from the next cycle.
  - Fetch always drives m_we=0 and m_size=00.
  - m_wdata is 0 unless the grant is a data store.
- IDLE, both requests: data wins, unless the starvation count equals STARVE_MAX, in which case fetch wins.
- Starvation counter:
  - Increments when fetch loses while i_req=1.
  - Clears when fetch is granted.
  - Saturates at STARVE_MAX.
- IBUS/DBUS: m_* outputs are held stable. The timeout counter increments every cycle.
  - m_ack_n sampled 0: capture m_rdata into i_rdata or d_rdata (d_rdata is 0 for stores), clear m_req, go to RESP, and pulse the matching ack in RESP.
  - Timeout counter reaches TIMEOUT_CYCLES-1 with no ack: clear m_req, go to RESP, pulse the ack with rdata=0 and err=1.
- RESP: no arbitration in this cycle, which gives the requester one cycle to drop its request. Always go to IDLE.
- Minimum latency, request to ack: 3 cycles when memory acks in the first bus cycle (IDLE, IBUS/DBUS, RESP). Back-to-back transactions are separated by the IDLE cycle.
- Request dropped during IBUS/DBUS: ignored. The transaction completes and the ack is still issued.
- Request inputs are sampled only in IDLE.
- m_ack_n low while in IDLE or RESP: ignored.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: when both requesters are pending in IDLE, the grant alternates. The one not granted last wins, tracked in a last_grant flip-flop that resets to "data". The starvation counter is not instantiated.
- Undefined: fixed data priority with the STARVE_MAX override described in Behaviour.

Decomposition:
- Package mem_bus_pkg holds:
  - the state enum (IDLE/IBUS/DBUS/RESP);
  - size codes SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10;
  - the timeout read value (0).
- One sub-module, mem_arb_pick, holds the grant decision and the starvation counter (or last_grant under MEM_ARB_RR_EN). The FSM, bus registers and timeout counter stay in the top module.

Test Plan:
- Fetch only, i_addr=0x100, memory acks in its first bus cycle with 0x24010005 -> m_req=1 for exactly 1 cycle with m_addr=0x100, m_we=0; i_ack pulses 3 cycles after the request with i_rdata=0x24010005.
- i_req and d_req (store, d_addr=0x2000, d_size=10, d_wdata=0x41) both asserted at the same edge -> data granted first with m_we=1, m_size=10, m_wdata=0x41; fetch granted on the next IDLE.
- d_req held continuously with STARVE_MAX=4 and i_req high -> exactly 4 data grants, then a fetch grant, then the counter resets. With MEM_ARB_RR_EN, the grants alternate D,I,D,I.
- Load with m_ack_n held high for 3 bus cycles then low, m_rdata=0xCAFEF00D -> m_* outputs stable throughout; d_ack with d_rdata=0xCAFEF00D; err=0.
- m_ack_n never asserted, TIMEOUT_CYCLES=8 -> m_req high for 8 cycles; d_ack=1, err=1, d_rdata=0 in the same cycle; then IDLE.
- rst=1 during DBUS -> next cycle m_req=0, no d_ack; a request presented after rst deasserts starts a clean grant.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Used by mem_bus_arbiter and mem_arb_pick (see MEM_ARB_RR_EN in those files).
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IBUS = 2'b01,
        DBUS = 2'b10,
        RESP = 2'b11
    } state_e;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    // Read data returned to a requester whose bus cycle was aborted.
    localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision between fetch and data requesters, evaluated only while arb_en is high.
// Default: data priority with a starvation override; `define MEM_ARB_RR_EN for alternating grants.
module mem_arb_pick
    import mem_bus_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic i_req,
    input  logic d_req,
    output logic grant_i,
    output logic grant_d
);

`ifdef MEM_ARB_RR_EN
    logic last_grant_i_r;   // 1: fetch was granted last, 0: data (reset value)

    // Grant selection: on contention the requester not granted last wins.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (arb_en && i_req && d_req) begin
            grant_i = ~last_grant_i_r;
            grant_d = last_grant_i_r;
        end else if (arb_en) begin
            grant_i = i_req;
            grant_d = d_req;
        end else begin
            grant_i = 1'b0;
            grant_d = 1'b0;
        end
    end

    // Remember who won the most recent grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_i_r <= 1'b0;
        end else if (grant_i) begin
            last_grant_i_r <= 1'b1;
        end else if (grant_d) begin
            last_grant_i_r <= 1'b0;
        end
    end
`else
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt_r;
    logic          force_i_s;

    assign force_i_s = (starve_cnt_r == STARVE_LIM);

    // Grant selection: data wins contention unless fetch has lost STARVE_MAX times in a row.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (arb_en && i_req && d_req) begin
            grant_i = force_i_s;
            grant_d = ~force_i_s;
        end else if (arb_en) begin
            grant_i = i_req;
            grant_d = d_req;
        end else begin
            grant_i = 1'b0;
            grant_d = 1'b0;
        end
    end

    // Count fetch losses; a fetch grant clears the count, which saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= '0;
        end else if (grant_i) begin
            starve_cnt_r <= '0;
        end else if (grant_d && i_req && !force_i_s) begin
            starve_cnt_r <= starve_cnt_r + SW'(1);
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between instruction fetch and data load/store.
// Grant policy lives in mem_arb_pick; `define MEM_ARB_RR_EN selects alternating grants.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int STARVE_MAX     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack_n,
    output logic              err
);

    localparam int              TMO_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_W-1:0] TMO_DATA = DATA_W'(TIMEOUT_RDATA);

    state_e            state_r, state_nxt_s;
    logic              arb_en_s, grant_i_s, grant_d_s;
    logic              ack_seen_s, tmo_hit_s;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic              m_req_r, m_we_r, i_ack_r, d_ack_r, err_r;
    logic [1:0]        m_size_r;
    logic [ADDR_W-1:0] m_addr_r;
    logic [DATA_W-1:0] m_wdata_r, i_rdata_r, d_rdata_r;

    assign arb_en_s = (state_r == IDLE);

    mem_arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_pick (
        .clk    (clk),
        .rst    (rst),
        .arb_en (arb_en_s),
        .i_req  (i_req),
        .d_req  (d_req),
        .grant_i(grant_i_s),
        .grant_d(grant_d_s)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state; an ack in the last allowed bus cycle beats the timeout.
    always_comb begin
        state_nxt_s = state_r;
        ack_seen_s  = 1'b0;
        tmo_hit_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    state_nxt_s = DBUS;
                end else if (grant_i_s) begin
                    state_nxt_s = IBUS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            IBUS, DBUS: begin
                if (m_ack_n == 1'b0) begin
                    ack_seen_s  = 1'b1;
                    state_nxt_s = RESP;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    tmo_hit_s   = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Bus registers, timeout counter, captured read data and completion pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_req_r   <= 1'b0;
            m_we_r    <= 1'b0;
            m_size_r  <= SZ_WORD;
            m_addr_r  <= '0;
            m_wdata_r <= '0;
            i_rdata_r <= '0;
            d_rdata_r <= '0;
            i_ack_r   <= 1'b0;
            d_ack_r   <= 1'b0;
            err_r     <= 1'b0;
            tmo_cnt_r <= '0;
        end else begin
            i_ack_r <= 1'b0;
            d_ack_r <= 1'b0;
            err_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    tmo_cnt_r <= '0;
                    if (grant_d_s) begin
                        m_req_r   <= 1'b1;
                        m_we_r    <= d_we;
                        m_size_r  <= d_size;
                        m_addr_r  <= d_addr;
                        m_wdata_r <= d_we ? d_wdata : '0;
                    end else if (grant_i_s) begin
                        m_req_r   <= 1'b1;
                        m_we_r    <= 1'b0;
                        m_size_r  <= SZ_WORD;
                        m_addr_r  <= i_addr;
                        m_wdata_r <= '0;
                    end
                end
                IBUS, DBUS: begin
                    if (ack_seen_s || tmo_hit_s) begin
                        m_req_r   <= 1'b0;
                        tmo_cnt_r <= '0;
                        err_r     <= tmo_hit_s;
                        if (state_r == IBUS) begin
                            i_ack_r   <= 1'b1;
                            i_rdata_r <= ack_seen_s ? m_rdata : TMO_DATA;
                        end else begin
                            d_ack_r   <= 1'b1;
                            // Stores return zero; only a completed load carries bus data.
                            if (tmo_hit_s) begin
                                d_rdata_r <= TMO_DATA;
                            end else if (m_we_r) begin
                                d_rdata_r <= '0;
                            end else begin
                                d_rdata_r <= m_rdata;
                            end
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
                end
                RESP: begin
                    tmo_cnt_r <= '0;
                end
                default: begin
                    m_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign m_req   = m_req_r;
    assign m_we    = m_we_r;
    assign m_size  = m_size_r;
    assign m_addr  = m_addr_r;
    assign m_wdata = m_wdata_r;
    assign i_rdata = i_rdata_r;
    assign d_rdata = d_rdata_r;
    assign i_ack   = i_ack_r;
    assign d_ack   = d_ack_r;
    assign err     = err_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed, table-driven bench for mem_bus_arbiter (default build, STARVE_MAX=4, TIMEOUT_CYCLES=8).
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, m_ack_n;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [1:0]  d_size;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_ack, d_ack, m_req, m_we, err;
    logic [1:0]  m_size;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack_n(m_ack_n), .err(err)
    );

    typedef struct {
        logic        is_d;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ack_dly;   // bus cycle index in which memory acks; >= 8 means never
        logic [31:0] mem_rdata;
        logic        exp_we;
        logic [1:0]  exp_size;
        logic [31:0] exp_wdata;
        int          exp_bus;   // cycles m_req stays high
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic is_d, input logic we, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int ack_dly, input logic [31:0] mem_rdata,
                                input logic exp_we, input logic [1:0] exp_size,
                                input logic [31:0] exp_wdata, input int exp_bus,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.is_d = is_d; v.we = we; v.size = size; v.addr = addr; v.wdata = wdata;
        v.ack_dly = ack_dly; v.mem_rdata = mem_rdata; v.exp_we = exp_we;
        v.exp_size = exp_size; v.exp_wdata = exp_wdata; v.exp_bus = exp_bus;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    // One single-requester transaction from IDLE through RESP and back to IDLE.
    task automatic run_txn(input vec_t v);
        int          b;
        logic        stable;
        logic [31:0] a0, w0;
        logic        we0;
        logic [1:0]  s0;
        @(negedge clk);
        m_rdata = v.mem_rdata;
        m_ack_n = 1'b1;
        d_we    = v.we;
        d_size  = v.size;
        d_wdata = v.wdata;
        if (v.is_d) begin
            d_req = 1'b1; d_addr = v.addr; i_req = 1'b0; i_addr = 32'h0000_0F00;
        end else begin
            i_req = 1'b1; i_addr = v.addr; d_req = 1'b0; d_addr = 32'h0000_0E00;
        end
        @(posedge clk); #1;
        chk("grant_m_req", m_req, 1'b1);
        chk("grant_m_addr", m_addr, v.addr);
        chk("grant_m_we", m_we, v.exp_we);
        chk("grant_m_size", m_size, v.exp_size);
        chk("grant_m_wdata", m_wdata, v.exp_wdata);
        a0 = m_addr; w0 = m_wdata; we0 = m_we; s0 = m_size;
        stable = 1'b1;
        b = 0;
        m_ack_n = (v.ack_dly == 0) ? 1'b0 : 1'b1;
        while (b < 40) begin
            @(posedge clk); #1;
            b++;
            if (m_req !== 1'b1) break;
            if (m_addr !== a0 || m_wdata !== w0 || m_we !== we0 || m_size !== s0) stable = 1'b0;
            m_ack_n = (b == v.ack_dly) ? 1'b0 : 1'b1;
        end
        m_ack_n = 1'b1;
        chk("bus_stable", stable, 1'b1);
        chk("bus_cycles", b, v.exp_bus);
        if (v.is_d) begin
            chk("d_ack", d_ack, 1'b1);
            chk("i_ack_quiet", i_ack, 1'b0);
            chk("d_rdata", d_rdata, v.exp_rdata);
        end else begin
            chk("i_ack", i_ack, 1'b1);
            chk("d_ack_quiet", d_ack, 1'b0);
            chk("i_rdata", i_rdata, v.exp_rdata);
        end
        chk("err", err, v.exp_err);
        i_req = 1'b0;
        d_req = 1'b0;
        @(posedge clk); #1;
        chk("ack_pulse_end", {i_ack, d_ack, err}, 3'b000);
    endtask

    // Waits for the next grant, acks it in its first bus cycle, returns at RESP+#1.
    task automatic serve_one(output logic [31:0] addr, output logic we, output logic [1:0] size,
                             output logic [31:0] wdata, output logic got_i, output logic got_d);
        int guard;
        guard = 0;
        while (m_req !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("serve_grant", m_req, 1'b1);
        addr = m_addr; we = m_we; size = m_size; wdata = m_wdata;
        m_ack_n = 1'b0;
        @(posedge clk); #1;
        m_ack_n = 1'b1;
        got_i = i_ack;
        got_d = d_ack;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "tb_mem_bus_arbiter stopped by watchdog");
    end

    initial begin
        logic [31:0] ga, gw;
        logic        gwe, gi, gd;
        logic [1:0]  gs;
        logic [9:0]  pattern;

        vecs[0] = mk(1'b0, 1'b1, 2'b10, 32'h0000_0100, 32'hFFFF_FFFF, 0, 32'h2401_0005,
                     1'b0, 2'b00, 32'h0, 1, 32'h2401_0005, 1'b0);
        vecs[1] = mk(1'b1, 1'b0, 2'b00, 32'h0000_3000, 32'hDEAD_BEEF, 3, 32'hCAFE_F00D,
                     1'b0, 2'b00, 32'h0, 4, 32'hCAFE_F00D, 1'b0);
        vecs[2] = mk(1'b1, 1'b1, 2'b10, 32'h0000_2000, 32'h0000_0041, 0, 32'hFFFF_FFFF,
                     1'b1, 2'b10, 32'h0000_0041, 1, 32'h0, 1'b0);
        vecs[3] = mk(1'b1, 1'b0, 2'b00, 32'h0000_3004, 32'h0, 99, 32'h5555_5555,
                     1'b0, 2'b00, 32'h0, 8, 32'h0, 1'b1);
        vecs[4] = mk(1'b0, 1'b0, 2'b00, 32'h0000_0108, 32'h0, 99, 32'h7777_7777,
                     1'b0, 2'b00, 32'h0, 8, 32'h0, 1'b1);
        vecs[5] = mk(1'b1, 1'b1, 2'b01, 32'h0000_2002, 32'h0000_1234, 1, 32'h0,
                     1'b1, 2'b01, 32'h0000_1234, 2, 32'h0, 1'b0);
        vecs[6] = mk(1'b0, 1'b0, 2'b00, 32'h0000_0104, 32'h0, 2, 32'h1234_5678,
                     1'b0, 2'b00, 32'h0, 3, 32'h1234_5678, 1'b0);
        vecs[7] = mk(1'b1, 1'b0, 2'b01, 32'h0000_2006, 32'h0000_ABCD, 7, 32'h0000_BEEF,
                     1'b0, 2'b01, 32'h0, 8, 32'h0000_BEEF, 1'b0);

        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 2'b00;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; m_rdata = 32'h0; m_ack_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {m_req, m_we, i_ack, d_ack, err}, 5'b00000);
        chk("rst_m_size", m_size, 2'b00);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_rdata", {i_rdata, d_rdata}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) run_txn(vecs[k]);

        // Contention: data store wins, fetch follows on the next IDLE.
        i_req = 1'b1; i_addr = 32'h0000_0200;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h0000_2000; d_wdata = 32'h0000_0041;
        serve_one(ga, gwe, gs, gw, gi, gd);
        chk("both_first_is_data", {gi, gd}, 2'b01);
        chk("both_first_addr", ga, 32'h0000_2000);
        chk("both_first_we_size", {gwe, gs}, 3'b110);
        chk("both_first_wdata", gw, 32'h0000_0041);
        d_req = 1'b0;
        serve_one(ga, gwe, gs, gw, gi, gd);
        chk("both_second_is_fetch", {gi, gd}, 2'b10);
        chk("both_second_addr", ga, 32'h0000_0200);
        chk("both_second_we_size", {gwe, gs}, 3'b000);
        i_req = 1'b0;

        // Starvation: both held; every fifth grant goes to fetch.
        i_req = 1'b1; i_addr = 32'h0000_0400;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h0000_3000;
        pattern = 10'b0;
        for (int k = 0; k < 10; k++) begin
            serve_one(ga, gwe, gs, gw, gi, gd);
            pattern[k] = gi;
            chk("starve_one_ack", gi ^ gd, 1'b1);
        end
        chk("starve_pattern", pattern, 10'b10_0001_0000);
        i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while a load is on the bus.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_5000;
        @(posedge clk); #1;
        chk("rst_mid_grant", m_req, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1; d_req = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_m_req", m_req, 1'b0);
        chk("rst_mid_no_ack", {d_ack, i_ack, err}, 3'b000);
        chk("rst_mid_m_addr", m_addr, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_after_no_ack", {d_ack, m_req}, 2'b00);
        run_txn(mk(1'b0, 1'b0, 2'b00, 32'h0000_0600, 32'h0, 0, 32'h1122_3344,
                   1'b0, 2'b00, 32'h0, 1, 32'h1122_3344, 1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
